// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_decoder
// Purpose  : Recovers pixel coordinates, a data-enable and a lock indication
//            from a raw 1-bit-per-colour VGA stream. Optional per-frame lit
//            pixel counter enabled by macro VGA_SYNC_DECODER_PIXCNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module vga_sync_decoder #(
  parameter int H_VIS = 640,
  parameter int H_FP  = 16,
  parameter int H_SW  = 96,
  parameter int H_TOT = 800,
  parameter int V_VIS = 480,
  parameter int V_FP  = 10,
  parameter int V_SW  = 2,
  parameter int V_TOT = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        VGA_RED,
  input  logic        VGA_GREEN,
  input  logic        VGA_BLUE,
  input  logic        VGA_HSYNC,
  input  logic        VGA_VSYNC,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        de,
  output logic [2:0]  rgb_out,
  output logic        locked,
  output logic        frame_start,
  output logic        timing_err,
  output logic [18:0] frame_pix_count
);

  localparam logic [9:0] C_SAT = 10'h3FF;

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_red, r_grn, r_blu, r_hs, r_vs, r_hs_d, r_vs_d;
  logic [9:0] r_hcnt, r_vcnt;
  logic [9:0] r_lp, r_hw, r_lines, r_vw;
  logic       r_lp_vld, r_hw_vld, r_lines_vld, r_vw_vld;
  logic       r_de, r_fs, r_locked, r_terr;
  logic [2:0] r_rgb;

  logic       w_hs_fall, w_hs_rise, w_vs_fall, w_vs_rise, w_hwrap, w_viol;
  logic       w_de_nxt, w_fs_nxt;
  logic [9:0] w_hcnt_nxt, w_vcnt_nxt;
  logic [2:0] w_rgb;

  assign w_hs_fall = r_hs_d & ~r_hs;
  assign w_hs_rise = ~r_hs_d & r_hs;
  assign w_vs_fall = r_vs_d & ~r_vs;
  assign w_vs_rise = ~r_vs_d & r_vs;
  assign w_rgb     = {r_red, r_grn, r_blu};

  // Counter next values describe the pixel now held in stage 1, so the
  // stage-2 coordinates line up with the colour registered alongside them.
  assign w_hwrap    = ~w_hs_fall && (r_hcnt == 10'(H_TOT - 1));
  assign w_hcnt_nxt = w_hs_fall ? 10'(H_VIS + H_FP) :
                      w_hwrap   ? 10'd0 : r_hcnt + 10'd1;
  assign w_vcnt_nxt = w_vs_fall ? 10'(V_VIS + V_FP) :
                      w_hwrap   ? ((r_vcnt == 10'(V_TOT - 1)) ? 10'd0 : r_vcnt + 10'd1) :
                      r_vcnt;

  assign w_de_nxt = r_locked && (w_hcnt_nxt < 10'(H_VIS)) && (w_vcnt_nxt < 10'(V_VIS));
  assign w_fs_nxt = w_de_nxt && (w_hcnt_nxt == 10'd0) && (w_vcnt_nxt == 10'd0);

  assign w_viol = (w_hs_fall  && r_lp_vld    && (r_lp    != 10'(H_TOT))) ||
                  (!w_hs_fall && r_lp_vld    && (r_lp    == 10'(H_TOT))) ||
                  (w_hs_rise  && r_hw_vld    && (r_hw    != 10'(H_SW)))  ||
                  (w_vs_fall  && r_lines_vld && (r_lines != 10'(V_TOT))) ||
                  (w_vs_rise  && r_vw_vld    && (r_vw    != 10'(V_SW)));

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_red, r_grn, r_blu, r_hs, r_vs, r_hs_d, r_vs_d} <= '0;
      r_hcnt <= '0;
      r_vcnt <= '0;
      r_de   <= 1'b0;
      r_rgb  <= '0;
      r_fs   <= 1'b0;
    end else begin
      {r_red, r_grn, r_blu} <= {VGA_RED, VGA_GREEN, VGA_BLUE};
      r_hs   <= VGA_HSYNC;
      r_vs   <= VGA_VSYNC;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
      r_hcnt <= w_hcnt_nxt;
      r_vcnt <= w_vcnt_nxt;
      r_de   <= w_de_nxt;
      r_rgb  <= w_de_nxt ? w_rgb : 3'b000;
      r_fs   <= w_fs_nxt;
    end
  end

  // Each measurement is only checked once a reference edge has been seen,
  // so a reset mid-frame never produces a spurious violation.
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_lp, r_hw, r_lines, r_vw} <= '0;
      {r_lp_vld, r_hw_vld, r_lines_vld, r_vw_vld} <= '0;
    end else begin
      if (w_hs_fall) begin
        r_lp     <= 10'd1;
        r_lp_vld <= 1'b1;
        r_hw     <= 10'd1;
        r_hw_vld <= 1'b1;
      end else begin
        if (r_lp != C_SAT) r_lp <= r_lp + 10'd1;
        if (!r_hs && r_hw != C_SAT) r_hw <= r_hw + 10'd1;
        if (w_hs_rise) r_hw_vld <= 1'b0;
      end
      if (w_vs_fall) begin
        r_lines     <= w_hs_fall ? 10'd1 : 10'd0;
        r_lines_vld <= 1'b1;
        r_vw        <= w_hs_fall ? 10'd1 : 10'd0;
        r_vw_vld    <= 1'b1;
      end else begin
        if (w_hs_fall && r_lines != C_SAT) r_lines <= r_lines + 10'd1;
        if (w_hs_fall && !r_vs && r_vw != C_SAT) r_vw <= r_vw + 10'd1;
        if (w_vs_rise) r_vw_vld <= 1'b0;
      end
    end
  end

  // A violation always wins over a coincident vsync edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_SEARCH;
      r_locked <= 1'b0;
      r_terr   <= 1'b0;
    end else begin
      r_terr <= w_viol && (r_state != S_SEARCH);
      case (r_state)
        S_SEARCH: begin
          if (w_vs_fall && !w_viol) r_state <= S_VERIFY;
        end
        S_VERIFY: begin
          if (w_viol) begin
            r_state <= S_SEARCH;
          end else if (w_vs_fall) begin
            r_state  <= S_LOCKED;
            r_locked <= 1'b1;
          end
        end
        S_LOCKED: begin
          if (w_viol) begin
            r_state  <= S_SEARCH;
            r_locked <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_SYNC_DECODER_PIXCNT_EN
  logic [18:0] r_pc, r_fpc;
  logic        w_lit;

  assign w_lit = w_de_nxt && (w_rgb != 3'b000);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= '0;
      r_fpc <= '0;
    end else if (w_fs_nxt) begin
      r_fpc <= r_pc;
      r_pc  <= w_lit ? 19'd1 : 19'd0;
    end else if (w_lit && r_pc != '1) begin
      r_pc <= r_pc + 19'd1;
    end
  end

  assign frame_pix_count = r_fpc;
`else
  assign frame_pix_count = '0;
`endif

  assign pixel_x     = r_hcnt;
  assign pixel_y     = r_vcnt;
  assign de          = r_de;
  assign rgb_out     = r_rgb;
  assign frame_start = r_fs;
  assign locked      = r_locked;
  assign timing_err  = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_decoder
// Purpose  : Directed frame stream with a scoreboard of expected outputs for
//            vga_sync_decoder, using a reduced raster to keep runs short.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_sync_decoder;
  localparam int H_VIS = 16, H_FP = 2, H_SW = 4, H_TOT = 26;
  localparam int V_VIS = 6,  V_FP = 2, V_SW = 2, V_TOT = 12;
  localparam int HS0 = H_VIS + H_FP;
  localparam int VS0 = V_VIS + V_FP;

  logic clk = 1'b0, rst = 1'b1;
  logic red = 1'b0, green = 1'b0, blue = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [9:0]  pixel_x, pixel_y;
  logic        de, locked, frame_start, timing_err;
  logic [2:0]  rgb_out;
  logic [18:0] frame_pix_count;

  typedef struct {
    bit          chk_pos;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic [2:0]  rgb;
    logic        fs;
    logic        lk;
    logic        te;
    bit          chk_fpc;
    logic [18:0] fpc;
  } ent_t;

  ent_t q[$];
  int   vectors = 0, miscompares = 0;
  int   lk = 0, acc = 0, obs_de = 0;
  bit   bad = 1'b0, pos_ok = 1'b0, rst_prev = 1'b0;

  vga_sync_decoder #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_TOT(H_TOT),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_TOT(V_TOT)
  ) dut (
    .clk(clk), .rst(rst),
    .VGA_RED(red), .VGA_GREEN(green), .VGA_BLUE(blue),
    .VGA_HSYNC(hs), .VGA_VSYNC(vs),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .de(de), .rgb_out(rgb_out),
    .locked(locked), .frame_start(frame_start), .timing_err(timing_err),
    .frame_pix_count(frame_pix_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One pixel clock: score the outputs due now, then drive the next pixel.
  task automatic step(input logic r, input logic h, input logic v,
                      input logic [2:0] c, input ent_t e);
    ent_t o;
    @(posedge clk);
    #1;
    if (rst_prev) begin
      chk("reset", {pixel_x, pixel_y, de, rgb_out, frame_start, locked,
                    timing_err, frame_pix_count}, 64'd0);
      q.delete();
    end else if (q.size() == 2) begin
      o = q.pop_front();
      if (o.chk_pos) chk("pos", {pixel_x, pixel_y}, {o.x, o.y});
      chk("video",  {de, rgb_out, frame_start}, {o.de, o.rgb, o.fs});
      chk("status", {locked, timing_err}, {o.lk, o.te});
      if (o.chk_fpc) chk("fpc", 64'(frame_pix_count), 64'(o.fpc));
      obs_de += int'(de);
    end
    rst = r;
    hs  = h;
    vs  = v;
    {red, green, blue} = c;
    rst_prev = r;
    if (!r) q.push_back(e);
  endtask

  // mode: 0 pattern, 1 all red, 2 all black. Fault lines use -1 for none.
  task automatic frame(input int mode, input int hs95_y, input int hshigh_y,
                       input int skip_y, input int rst_at, input int rst_len);
    ent_t e;
    logic r, hlo, vlo;
    logic [2:0] c;
    int lk_b, idx;
    for (int y = 0; y < V_TOT; y++) begin
      if (y == skip_y) begin
        bad = 1'b1;
        continue;
      end
      for (int x = 0; x < H_TOT; x++) begin
        idx = y * H_TOT + x;
        r   = (idx >= rst_at) && (idx < rst_at + rst_len);
        hlo = (y != hshigh_y) && (x >= HS0) &&
              (x < HS0 + ((y == hs95_y) ? H_SW - 1 : H_SW));
        vlo = (y >= VS0) && (y < VS0 + V_SW);
        c   = (mode == 1) ? 3'b100 : (mode == 2) ? 3'b000 : 3'((x + y) % 8);
        e   = '{default: '0};
        if (r) begin
          lk = 0; bad = 1'b0; pos_ok = 1'b0; acc = 0;
        end else begin
          lk_b = lk;
          if (x == 0 && y == VS0) begin
            if (bad) begin
              e.te = (lk != 0);
              lk = 0;
            end else begin
              lk = (lk == 2) ? 2 : lk + 1;
            end
            bad = 1'b0;
            pos_ok = 1'b1;
          end
          if (y == hs95_y && x == HS0 + H_SW - 1) begin
            e.te = (lk != 0);
            lk = 0;
          end
          if (y == hshigh_y && x == HS0) begin
            e.te = (lk != 0);
            lk = 0;
            bad = 1'b1;
          end
          e.chk_pos = pos_ok;
          e.x   = 10'(x);
          e.y   = 10'(y);
          e.de  = (lk_b == 2) && (x < H_VIS) && (y < V_VIS);
          e.rgb = e.de ? c : 3'b000;
          e.fs  = e.de && x == 0 && y == 0;
          e.lk  = (lk == 2);
          if (e.fs) begin
            e.chk_fpc = 1'b1;
`ifdef VGA_SYNC_DECODER_PIXCNT_EN
            e.fpc = 19'(acc);
`else
            e.fpc = 19'd0;
`endif
            acc = 0;
          end
          if (e.de && e.rgb != 3'b000) acc++;
        end
        step(r, !hlo, !vlo, c, e);
      end
    end
  endtask

  initial begin
    int d0;
    frame(0, -1, -1, -1, 0, 30);             // 300 ns reset, then VERIFY
    frame(0, -1, -1, -1, -1, 0);             // locks at this vsync edge
    d0 = obs_de;
    frame(0, -1, -1, -1, -1, 0);             // fully locked frame
    chk("de_count", 64'(obs_de - d0), 64'(H_VIS * V_VIS));
    frame(1, -1, -1, -1, -1, 0);             // all red
    frame(2, V_VIS, -1, -1, -1, 0);          // all black, short hsync pulse
    frame(0, -1, -1, -1, -1, 0);
    frame(0, -1, V_VIS, -1, -1, 0);          // missing hsync pulse
    frame(0, -1, -1, -1, -1, 0);
    frame(0, -1, -1, -1, -1, 0);
    frame(0, -1, -1, -1, 3 * H_TOT, 2);      // reset mid-frame while locked
    frame(0, -1, -1, -1, -1, 0);
    frame(0, -1, -1, -1, H_TOT, 1);          // reset, leaves VERIFY at vsync
    frame(0, -1, -1, VS0 - 1, -1, 0);        // one line short while in VERIFY
    frame(0, -1, -1, -1, -1, 0);
    frame(0, -1, -1, -1, -1, 0);
    frame(1, -1, -1, -1, -1, 0);
    frame(0, -1, -1, -1, -1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_VIS 640 active pixels; H_FP 16 front porch; H_SW 96 hsync width; H_TOT 800 clocks per line; V_VIS 480 active lines; V_FP 10 front porch lines; V_SW 2 vsync width in lines; V_TOT 525 lines per frame.
REQ-002 SHALL have ports (name, direction, width, meaning): clk in 1 pixel clock, one pixel per cycle; rst in 1 synchronous active-high reset; VGA_RED in 1; VGA_GREEN in 1; VGA_BLUE in 1; VGA_HSYNC in 1 active-low; VGA_VSYNC in 1 active-low; pixel_x out 10; pixel_y out 10; de out 1 active-pixel strobe; rgb_out out 3 {R,G,B}; locked out 1; frame_start out 1 pulse; timing_err out 1 pulse; frame_pix_count out 19.
REQ-003 SHALL run on a single clock, clk; inputs are synchronous to clk (no synchronizer).

Function
REQ-004 SHALL register all five VGA inputs once (stage 1); edges are detected on stage-1 values against their previous values.
REQ-005 SHALL keep horizontal counter hcnt: on an hsync falling edge load H_VIS+H_FP (656); otherwise increment, wrapping H_TOT-1 -> 0.
REQ-006 SHALL keep vertical counter vcnt: on a vsync falling edge load V_VIS+V_FP (490); otherwise increment when hcnt wraps 799 -> 0, wrapping V_TOT-1 -> 0.
REQ-007 SHALL measure line period (clocks between hsync falling edges, saturating at 1023), hsync low width (clocks), lines per frame (hsync falling edges between vsync falling edges) and vsync width (hsync falling edges while vsync low).
REQ-008 SHALL declare a violation when: line period != H_TOT at an hsync falling edge; line-period counter reaches H_TOT with no hsync edge; hsync low width != H_SW at hsync rising edge; lines per frame != V_TOT at vsync falling edge; vsync width != V_SW at vsync rising edge.
REQ-009 SHALL implement FSM SEARCH -> VERIFY -> LOCKED: SEARCH -> VERIFY on vsync falling edge; VERIFY -> LOCKED on next vsync falling edge with no violation since entry; VERIFY/LOCKED -> SEARCH on any violation.
REQ-010 SHALL, when a violation and a vsync falling edge occur in the same cycle, treat the violation as dominant (-> SEARCH, no lock).
REQ-011 SHALL pulse timing_err for one cycle per violation cycle only in VERIFY or LOCKED; violations in SEARCH are silent.
REQ-012 SHALL assert locked while FSM is LOCKED, first high one cycle after the locking vsync edge is detected.
REQ-013 SHALL drive pixel_x=hcnt, pixel_y=vcnt, rgb_out and de as registered outputs (stage 2); latency from input pins to these outputs is exactly 2 clocks.
REQ-014 SHALL drive de = locked AND hcnt<H_VIS AND vcnt<V_VIS; rgb_out SHALL be 3'b000 when de is low.
REQ-015 SHALL pulse frame_start for one cycle, aligned with de, at pixel (0,0) while locked.

Reset
REQ-016 SHALL, on rst high at a clk edge, clear all counters, registers and measurement state, enter SEARCH, and drive pixel_x=0, pixel_y=0, de=0, rgb_out=0, locked=0, frame_start=0, timing_err=0, frame_pix_count=0.
REQ-017 SHALL, after reset released mid-frame, require a full SEARCH -> VERIFY -> LOCKED sequence (two vsync falling edges) before locked rises.

Configuration
REQ-018 SHALL, with macro VGA_SYNC_DECODER_PIXCNT_EN defined, count cycles with de high and rgb_out != 0 per frame, saturating at 2^19-1, and load the count into frame_pix_count on frame_start (count covering the preceding frame).
REQ-019 SHALL, without VGA_SYNC_DECODER_PIXCNT_EN, keep port frame_pix_count and tie it to 0; no counter logic synthesized.

Verification
REQ-020 Nominal 640x480 stream, reset 300 ns -> locked high 1 cycle after second vsync falling edge; 307200 de cycles per frame; timing_err never pulses.
REQ-021 One line with hsync low 95 clocks while locked -> one timing_err pulse at hsync rising edge; locked low next cycle; relock after two further good vsync edges.
REQ-022 Hsync held high while locked -> timing_err pulse when line-period counter reaches 800; locked drops.
REQ-023 Frame with 524 lines in VERIFY -> timing_err at vsync edge, FSM to SEARCH, locked stays low.
REQ-024 rst pulsed mid-frame while locked -> all outputs 0 next cycle; locked returns only after two vsync falling edges.
REQ-025 PIXCNT_EN defined, all-red frame -> frame_pix_count=307200 at next frame_start; all-black frame -> 0; macro undefined -> always 0.
